// File: rtl/multi_fetcher_pkg.sv
// Shared definitions for the multi-channel value fetcher: channel FSM encodings,
// memory read latency and a small state helper.
package multi_fetcher_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Cycles from the registered read strobe to valid read data.
    localparam int MEM_LAT = 1;

    function automatic logic is_active(input logic [1:0] st);
        return (st == ST_FETCH) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/multi_fetcher_fetch_fifo.sv
// Per-channel first-word-fall-through FIFO with occupancy output.
// Latency: push visible at the head the cycle after the push edge; pop while empty is ignored.
// Backpressure: none internally; the fetcher's credit check keeps pushes within capacity.
module fetch_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    output logic [DW-1:0]            head_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occ
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != (PW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign empty    = (cnt == '0);
    assign occ      = cnt;
    assign head_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/multi_fetcher.sv
// N-channel value fetcher: streams per-channel address ranges from one shared memory into FWFT FIFOs.
// Latency: request 1 cycle after start, data lands in the channel FIFO 1+MEM_LAT cycles after the request.
// Backpressure: a channel requests only while FIFO occupancy plus reads in flight is below depth.
module multi_fetcher
    import multi_fetcher_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DW         = 8,
    parameter int AW         = 10,
    parameter int LW         = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NCH*AW-1:0] base_addr,
    input  logic [NCH*LW-1:0] len,
    output logic              busy,
    output logic [NCH-1:0]    done,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_rd_data,
    input  logic [NCH-1:0]    val_read,
    output logic [NCH*DW-1:0] val_out,
    output logic [NCH-1:0]    empty
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]         st_q    [NCH];
    logic [AW-1:0]      addr_q  [NCH];
    logic [LW-1:0]      rem_q   [NCH];
    logic [OW-1:0]      occ     [NCH];
    logic [DW-1:0]      head    [NCH];

    logic [CW-1:0]      rr_ptr_q;
    logic [CW-1:0]      req_ch_q;
    logic [MEM_LAT-1:0] ret_vld_q;
    logic [CW-1:0]      ret_ch_q [MEM_LAT];

    logic [NCH-1:0]     elig;
    logic [NCH-1:0]     infl_zero;
    logic [NCH-1:0]     fifo_push;
    logic               gnt_vld;
    logic [CW-1:0]      gnt_ch;
    logic               start_ok;

    always_comb begin
        busy = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (is_active(st_q[c])) busy = 1'b1;
        end
    end

    assign start_ok = start && !busy;

    // Credit: everything requested but not yet pushed counts against the FIFO.
    always_comb begin
        int n;
        n         = 0;
        elig      = '0;
        infl_zero = '0;
        for (int c = 0; c < NCH; c++) begin
            n = (mem_rd_en && (int'(req_ch_q) == c)) ? 1 : 0;
            for (int s = 0; s < MEM_LAT; s++) begin
                if (ret_vld_q[s] && (int'(ret_ch_q[s]) == c)) n = n + 1;
            end
            infl_zero[c] = (n == 0);
            elig[c]      = (st_q[c] == ST_FETCH) && (rem_q[c] != '0) &&
                           ((int'(occ[c]) + n) < FIFO_DEPTH);
        end
    end

    // Round-robin: search starts at the channel after the last grant.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            req_ch_q  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            ret_vld_q <= '0;
            for (int s = 0; s < MEM_LAT; s++) ret_ch_q[s] <= '0;
        end else begin
            mem_rd_en    <= gnt_vld;
            ret_vld_q[0] <= mem_rd_en;
            ret_ch_q[0]  <= req_ch_q;
            for (int s = 1; s < MEM_LAT; s++) begin
                ret_vld_q[s] <= ret_vld_q[s-1];
                ret_ch_q[s]  <= ret_ch_q[s-1];
            end
            if (gnt_vld) begin
                mem_addr <= addr_q[gnt_ch];
                req_ch_q <= gnt_ch;
                rr_ptr_q <= (gnt_ch == CW'(NCH-1)) ? '0 : gnt_ch + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                st_q[c]   <= ST_IDLE;
                addr_q[c] <= '0;
                rem_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                case (st_q[c])
                    ST_IDLE, ST_DONE: begin
                        if (start_ok) begin
                            addr_q[c] <= base_addr[c*AW +: AW];
                            rem_q[c]  <= len[c*LW +: LW];
                            st_q[c]   <= (len[c*LW +: LW] == '0) ? ST_DONE : ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (gnt_vld && (int'(gnt_ch) == c)) begin
                            addr_q[c] <= addr_q[c] + AW'(1);
                            rem_q[c]  <= rem_q[c] - LW'(1);
                            if (rem_q[c] == LW'(1)) st_q[c] <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (empty[c] && infl_zero[c]) st_q[c] <= ST_DONE;
                    end
                    default: st_q[c] <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign fifo_push[c] = ret_vld_q[MEM_LAT-1] && (ret_ch_q[MEM_LAT-1] == CW'(c));

        fetch_fifo #(
            .DW    (DW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (fifo_push[c]),
            .push_dat (mem_rd_data),
            .pop      (val_read[c]),
            .head_dat (head[c]),
            .empty    (empty[c]),
            .occ      (occ[c])
        );

        assign val_out[c*DW +: DW] = head[c];
        assign done[c]             = (st_q[c] == ST_DONE);
    end

endmodule

// File: tb/tb_multi_fetcher.sv
// Bench for multi_fetcher: memory returns the low address byte one cycle after each read,
// and per-channel expected value queues are built from base/len.
module tb_multi_fetcher;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [39:0] base_addr;
    logic [39:0] len;
    logic        busy;
    logic [3:0]  done;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_rd_data;
    logic [3:0]  val_read;
    logic [31:0] val_out;
    logic [3:0]  empty;

    int errors = 0;
    int checks = 0;
    logic [9:0] rd_log [$];
    logic [7:0] exp_q [4][$];

    multi_fetcher dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .val_read(val_read), .val_out(val_out), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_addr[7:0] : 8'($urandom);

    always @(negedge clk) if (mem_rd_en === 1'b1) rd_log.push_back(mem_addr);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; val_read = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_log.delete();
        for (int c = 0; c < 4; c++) exp_q[c].delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; val_read = '0; base_addr = '0; len = {4{10'd3}};
        for (int i = 0; i < 3; i++) begin
            start = (i == 2);
            @(negedge clk);
            checks++; if (empty !== 4'hF) begin errors++; $display("FAIL reset_empty: got %h want f", empty); end
            checks++; if (val_out !== 32'h0) begin errors++; $display("FAIL reset_val_out: got %h want 0", val_out); end
            checks++; if (busy !== 1'b0 || done !== 4'h0) begin errors++; $display("FAIL reset_busy_done: got busy=%b done=%h want 0/0", busy, done); end
            checks++; if (mem_rd_en !== 1'b0 || mem_addr !== 10'd0) begin errors++; $display("FAIL reset_mem: got en=%b addr=%0d want 0/0", mem_rd_en, mem_addr); end
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL start_with_rst: got busy=%b en=%b want 0/0", busy, mem_rd_en); end
        rd_log.delete();
    endtask

    task automatic test_rr_order();
        logic [9:0] b [4];
        logic [9:0] ea;
        logic [3:0] vr;
        int left, pops, cyc;
        do_reset();
        b = '{10'd0, 10'd10, 10'd20, 10'd30};
        base_addr = {b[3], b[2], b[1], b[0]};
        len = {4{10'd3}};
        pulse_start();
        repeat (20) @(negedge clk);
        checks++; if (rd_log.size() != 12) begin errors++; $display("FAIL rr_count: got %0d want 12", rd_log.size()); end
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                ea = b[c] + 10'(k);
                checks++;
                if (k*4+c >= rd_log.size() || rd_log[k*4+c] !== ea) begin
                    errors++; $display("FAIL rr_addr[%0d]: got %0d want %0d", k*4+c, (k*4+c < rd_log.size()) ? int'(rd_log[k*4+c]) : -1, ea);
                end
                exp_q[c].push_back(ea[7:0]);
            end
        end
        checks++; if (empty !== 4'h0) begin errors++; $display("FAIL rr_empty: got %h want 0", empty); end
        checks++; if (val_out !== {8'd30, 8'd20, 8'd10, 8'd0}) begin errors++; $display("FAIL rr_head: got %h want 1e140a00", val_out); end
        checks++; if (busy !== 1'b1 || done !== 4'h0) begin errors++; $display("FAIL rr_busy: got busy=%b done=%h want 1/0", busy, done); end
        // Random pops, including pops of empty channels.
        left = 12; pops = 0; cyc = 0;
        while (left > 0 && cyc < 300) begin
            vr = 4'($urandom);
            for (int c = 0; c < 4; c++) begin
                if (vr[c] && !empty[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0) begin errors++; $display("FAIL rr_extra_pop ch%0d: got %h want none", c, val_out[c*8 +: 8]); end
                    else begin
                        ea[7:0] = exp_q[c].pop_front();
                        left--;
                        if (val_out[c*8 +: 8] !== ea[7:0]) begin errors++; $display("FAIL rr_pop ch%0d: got %h want %h", c, val_out[c*8 +: 8], ea[7:0]); end
                    end
                    pops++;
                end
            end
            val_read = vr;
            @(negedge clk);
            cyc++;
        end
        val_read = '0;
        checks++; if (pops != 12) begin errors++; $display("FAIL rr_pop_count: got %0d want 12", pops); end
        for (int i = 0; i < 10 && done !== 4'hF; i++) @(negedge clk);
        checks++; if (done !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL rr_done: got done=%h busy=%b want f/0", done, busy); end
    endtask

    task automatic test_credit();
        int cnt [4];
        logic [9:0] b [4];
        do_reset();
        b = '{10'd0, 10'd10, 10'd20, 10'd30};
        base_addr = {b[3], b[2], b[1], b[0]};
        len = {4{10'd8}};
        pulse_start();
        repeat (24) @(negedge clk);
        cnt = '{0, 0, 0, 0};
        foreach (rd_log[i]) for (int c = 0; c < 4; c++) if (rd_log[i] >= b[c] && rd_log[i] < b[c] + 10'd8) cnt[c]++;
        for (int c = 0; c < 4; c++) begin
            checks++; if (cnt[c] != 4) begin errors++; $display("FAIL credit_words ch%0d: got %0d want 4", c, cnt[c]); end
        end
        checks++; if (rd_log.size() != 16 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL credit_stop: got reads=%0d en=%b want 16/0", rd_log.size(), mem_rd_en); end
        rd_log.delete();
        checks++; if (val_out[23:16] !== 8'd20) begin errors++; $display("FAIL credit_head2: got %0d want 20", val_out[23:16]); end
        val_read = 4'b0100;
        @(negedge clk);
        val_read = '0;
        repeat (8) @(negedge clk);
        checks++; if (rd_log.size() != 1 || rd_log[0] !== 10'd24) begin errors++; $display("FAIL credit_refill: got n=%0d addr=%0d want 1/24", rd_log.size(), (rd_log.size() > 0) ? int'(rd_log[0]) : -1); end
        checks++; if (val_out[23:16] !== 8'd21) begin errors++; $display("FAIL credit_next2: got %0d want 21", val_out[23:16]); end
    endtask

    task automatic test_stream();
        logic [9:0] b, ea;
        int left, cyc;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            b = 10'($urandom_range(0, 1023));
            base_addr[c*10 +: 10] = b;
            for (int k = 0; k < 5; k++) begin ea = b + 10'(k); exp_q[c].push_back(ea[7:0]); end
        end
        len = {4{10'd5}};
        val_read = 4'hF;
        pulse_start();
        left = 20; cyc = 0;
        while (left > 0 && cyc < 200) begin
            for (int c = 0; c < 4; c++) begin
                if (!empty[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0) begin errors++; $display("FAIL stream_dup ch%0d: got %h want none", c, val_out[c*8 +: 8]); end
                    else begin
                        ea[7:0] = exp_q[c].pop_front();
                        left--;
                        if (val_out[c*8 +: 8] !== ea[7:0]) begin errors++; $display("FAIL stream_val ch%0d: got %h want %h", c, val_out[c*8 +: 8], ea[7:0]); end
                    end
                end
            end
            if (left > 0) begin @(negedge clk); cyc++; end
        end
        checks++; if (left != 0) begin errors++; $display("FAIL stream_timeout: got %0d words missing want 0", left); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_early_done: got busy=%b want 1", busy); end
        @(negedge clk);
        checks++; if (done !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL stream_done: got done=%h busy=%b want f/0", done, busy); end
        val_read = '0;
    endtask

    task automatic test_zero_len();
        logic [9:0] b1, ea;
        do_reset();
        b1 = 10'($urandom_range(0, 1023));
        base_addr = {20'd0, b1, 10'd0};
        len = {10'd0, 10'd0, 10'd2, 10'd0};
        pulse_start();
        checks++; if (done !== 4'b1101 || busy !== 1'b1) begin errors++; $display("FAIL zero_done: got done=%h busy=%b want d/1", done, busy); end
        len = {4{10'd1}};
        pulse_start();
        len = {10'd0, 10'd0, 10'd2, 10'd0};
        val_read = 4'hF;
        for (int i = 0; i < 30 && busy !== 1'b0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        val_read = '0;
        checks++; if (busy !== 1'b0 || done !== 4'hF) begin errors++; $display("FAIL zero_finish: got busy=%b done=%h want 0/f", busy, done); end
        checks++; if (rd_log.size() != 2) begin errors++; $display("FAIL zero_reads: got %0d want 2", rd_log.size()); end
        for (int k = 0; k < 2; k++) begin
            ea = b1 + 10'(k);
            checks++;
            if (k >= rd_log.size() || rd_log[k] !== ea) begin errors++; $display("FAIL zero_addr[%0d]: got %0d want %0d", k, (k < rd_log.size()) ? int'(rd_log[k]) : -1, ea); end
        end
    endtask

    task automatic test_reset_abort();
        logic [9:0] want [4];
        do_reset();
        base_addr = {$urandom, 8'($urandom)};
        len = {4{10'd8}};
        pulse_start();
        for (int i = 0; i < 5 && mem_rd_en !== 1'b1; i++) @(negedge clk);
        checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL abort_no_read: got en=%b want 1", mem_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (empty !== 4'hF || busy !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL abort_state: got empty=%h busy=%b en=%b want f/0/0", empty, busy, mem_rd_en); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (empty !== 4'hF) begin errors++; $display("FAIL abort_late_data: got empty=%h want f", empty); end
        end
        rd_log.delete();
        base_addr = {30'd0, 10'd1022};
        len = {10'd0, 10'd0, 10'd0, 10'd4};
        pulse_start();
        repeat (12) @(negedge clk);
        want = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        checks++; if (rd_log.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", rd_log.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= rd_log.size() || rd_log[k] !== want[k]) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, (k < rd_log.size()) ? int'(rd_log[k]) : -1, want[k]); end
        end
        checks++; if (val_out[7:0] !== 8'd254) begin errors++; $display("FAIL wrap_head: got %0d want 254", val_out[7:0]); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; val_read = '0; base_addr = '0; len = '0;
        test_reset();
        test_rr_order();
        test_credit();
        test_stream();
        test_zero_len();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
